// File: rtl/ahb_gpio_parity.sv
// AHB-Lite GPIO slave: 16-bit data port plus one parity bit, zero wait states.
// Registers: 0x00 data (out on write / in on read), 0x04 direction (bit 0).
//
// Ports:
//   HCLK, HRESETn        bus clock; asynchronous reset, active HIGH (name kept)
//   HADDR/HTRANS/HWRITE  AHB address phase (HADDR[7:0] decoded)
//   HSEL/HREADY          slave select, bus ready
//   HWDATA/HRDATA        write data (data phase) / combinational read data
//   HREADYOUT            always 1
//   GPIOIN               [15:0] input data, [16] incoming parity bit
//   GPIOOUT              [15:0] data-out register, [16] generated parity
//   PARITYSEL            0 = even parity, 1 = odd parity
//   PARITYERR            registered parity error on sampled input
//   GPIODIR              1 = output, 0 = input
//
// Optional feature macro GPIO_PARITY_EN: when undefined, GPIOOUT[16] and
// PARITYERR are tied 0 and GPIOIN[16]/PARITYSEL are ignored.

module ahb_gpio_parity #(
    parameter int GPIO_WIDTH = 16
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic [31:0]           HADDR,
    input  logic [1:0]            HTRANS,
    input  logic [31:0]           HWDATA,
    input  logic                  HWRITE,
    input  logic                  HSEL,
    input  logic                  HREADY,
    input  logic [GPIO_WIDTH:0]   GPIOIN,
    input  logic                  PARITYSEL,
    output logic                  HREADYOUT,
    output logic [31:0]           HRDATA,
    output logic [GPIO_WIDTH:0]   GPIOOUT,
    output logic                  PARITYERR,
    output logic                  GPIODIR
);

    localparam logic [7:0] ADDR_DATA = 8'h00;
    localparam logic [7:0] ADDR_DIR  = 8'h04;

    logic                  addr_valid;
    logic [7:0]            addr_q;
    logic                  write_q;
    logic [GPIO_WIDTH-1:0] data_out;
    logic [GPIO_WIDTH-1:0] data_in;
    logic                  dir;
    logic                  parity_out;
    logic [31:0]           rdata;

    // Address phase capture plus data phase register writes and input sampling.
    always_ff @(posedge HCLK or posedge HRESETn) begin
        if (HRESETn) begin
            addr_valid <= 1'b0;
            addr_q     <= 8'h00;
            write_q    <= 1'b0;
            data_out   <= '0;
            data_in    <= '0;
            dir        <= 1'b0;
        end else begin
            addr_valid <= HSEL & HREADY & HTRANS[1];
            addr_q     <= HADDR[7:0];
            write_q    <= HWRITE;
            if (addr_valid && write_q) begin
                case (addr_q)
                    ADDR_DATA: data_out <= HWDATA[GPIO_WIDTH-1:0];
                    ADDR_DIR:  dir      <= HWDATA[0];
                    default:   ;
                endcase
            end
            if (!dir) begin
                data_in <= GPIOIN[GPIO_WIDTH-1:0];
            end
        end
    end

`ifdef GPIO_PARITY_EN
    logic perr;
    logic perr_next;

    // Odd parity is the inverted even parity, so PARITYSEL folds in as an XOR.
    assign parity_out = (^data_out) ^ PARITYSEL;
    assign perr_next  = GPIOIN[GPIO_WIDTH]
                        != ((^GPIOIN[GPIO_WIDTH-1:0]) ^ PARITYSEL);

    always_ff @(posedge HCLK or posedge HRESETn) begin
        if (HRESETn) begin
            perr <= 1'b0;
        end else if (!dir) begin
            perr <= perr_next;
        end
    end

    assign PARITYERR = perr;

    logic unused_bits;
    assign unused_bits = ^{HADDR[31:8], HTRANS[0],
                           HWDATA[31:GPIO_WIDTH]};
`else
    assign parity_out = 1'b0;
    assign PARITYERR  = 1'b0;

    logic unused_bits;
    assign unused_bits = ^{HADDR[31:8], HTRANS[0],
                           HWDATA[31:GPIO_WIDTH],
                           GPIOIN[GPIO_WIDTH], PARITYSEL};
`endif

    // Read data is driven only during the data phase of a valid read.
    always_comb begin
        rdata = '0;
        if (addr_valid && !write_q) begin
            case (addr_q)
                ADDR_DATA: rdata[GPIO_WIDTH-1:0] = dir ? data_out : data_in;
                ADDR_DIR:  rdata[0]              = dir;
                default:   rdata                 = '0;
            endcase
        end
    end

    assign HRDATA    = rdata;
    assign HREADYOUT = 1'b1;
    assign GPIOOUT   = {parity_out, data_out};
    assign GPIODIR   = dir;

endmodule

// File: tb/tb_ahb_gpio_parity.sv
// Self-checking bench for ahb_gpio_parity.
// Reads push expected data to a scoreboard queue; data phases pop and compare.

module tb_ahb_gpio_parity;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [31:0] HWDATA;
    logic        HWRITE;
    logic        HSEL;
    logic        HREADY;
    logic [16:0] GPIOIN;
    logic        PARITYSEL;
    logic        HREADYOUT;
    logic [31:0] HRDATA;
    logic [16:0] GPIOOUT;
    logic        PARITYERR;
    logic        GPIODIR;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];

    always #5 HCLK = ~HCLK;

    ahb_gpio_parity #(.GPIO_WIDTH(16)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWDATA(HWDATA), .HWRITE(HWRITE), .HSEL(HSEL), .HREADY(HREADY),
        .GPIOIN(GPIOIN), .PARITYSEL(PARITYSEL), .HREADYOUT(HREADYOUT),
        .HRDATA(HRDATA), .GPIOOUT(GPIOOUT), .PARITYERR(PARITYERR),
        .GPIODIR(GPIODIR)
    );

    function automatic logic [16:0] exp_out(input logic [15:0] d,
                                            input logic psel);
`ifdef GPIO_PARITY_EN
        logic p;
        p = 1'b0;
        for (int i = 0; i < 16; i++) p = p ^ d[i];
        return {p ^ psel, d};
`else
        return {1'b0, d};
`endif
    endfunction

    function automatic logic exp_perr(input logic [16:0] gin,
                                      input logic psel);
`ifdef GPIO_PARITY_EN
        logic [16:0] gen;
        gen = exp_out(gin[15:0], psel);
        return gin[16] != gen[16];
`else
        return 1'b0;
`endif
    endfunction

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic bus_idle();
        HSEL   = 1'b0;
        HTRANS = 2'b00;
        HWRITE = 1'b0;
        HADDR  = 32'h0;
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
        HSEL   = 1'b1;
        HTRANS = 2'b10;
        HWRITE = 1'b1;
        HADDR  = {24'h0, a};
        step();
        bus_idle();
        HWDATA = d;
        step();
    endtask

    task automatic read_check(input logic [7:0] a, input logic [31:0] e,
                              input string name);
        logic [31:0] want;
        exp_q.push_back(e);
        HSEL   = 1'b1;
        HTRANS = 2'b10;
        HWRITE = 1'b0;
        HADDR  = {24'h0, a};
        step();
        bus_idle();
        #2;
        want = exp_q.pop_front();
        checks++;
        if (HRDATA !== want || HREADYOUT !== 1'b1) begin
            errors++;
            $display("FAIL %s: HRDATA=%h HREADYOUT=%b expected %h/1",
                     name, HRDATA, HREADYOUT, want);
        end
    endtask

    task automatic test_reset();
        HRESETn = 1'b1;
        repeat (5) step();
        #2;
        checks++;
        if (GPIOOUT !== exp_out(16'h0, PARITYSEL) || GPIODIR !== 1'b0 ||
            PARITYERR !== 1'b0 || HRDATA !== 32'h0 || HREADYOUT !== 1'b1) begin
            errors++;
            $display("FAIL reset: out=%h dir=%b perr=%b rd=%h rdy=%b",
                     GPIOOUT, GPIODIR, PARITYERR, HRDATA, HREADYOUT);
        end
        HRESETn = 1'b0;
        step();
    endtask

    task automatic test_output();
        bus_write(8'h04, 32'h1);
        checks++;
        if (GPIODIR !== 1'b1) begin
            errors++;
            $display("FAIL dir_set: GPIODIR=%b expected 1", GPIODIR);
        end
        bus_write(8'h00, 32'hFFFF_00A5);
        PARITYSEL = 1'b0;
        #1;
        checks++;
        if (GPIOOUT !== exp_out(16'h00A5, 1'b0)) begin
            errors++;
            $display("FAIL out_even: GPIOOUT=%h expected %h",
                     GPIOOUT, exp_out(16'h00A5, 1'b0));
        end
        PARITYSEL = 1'b1;
        #1;
        checks++;
        if (GPIOOUT !== exp_out(16'h00A5, 1'b1)) begin
            errors++;
            $display("FAIL out_odd: GPIOOUT=%h expected %h",
                     GPIOOUT, exp_out(16'h00A5, 1'b1));
        end
        PARITYSEL = 1'b0;
        read_check(8'h00, 32'h0000_00A5, "read_out");
    endtask

    task automatic test_input();
        logic [16:0] pats[4] = '{17'h1_0001, 17'h0_0001,
                                 17'h0_8003, 17'h1_FFFF};
        logic        psels[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        bus_write(8'h04, 32'h0);
        for (int i = 0; i < 4; i++) begin
            GPIOIN    = pats[i];
            PARITYSEL = psels[i];
            step();
            #2;
            checks++;
            if (PARITYERR !== exp_perr(pats[i], psels[i])) begin
                errors++;
                $display("FAIL perr_%0d: PARITYERR=%b expected %b", i,
                         PARITYERR, exp_perr(pats[i], psels[i]));
            end
            read_check(8'h00, {16'h0, pats[i][15:0]}, "read_in");
        end
        // Write to data-out while in input mode still reaches GPIOOUT.
        bus_write(8'h00, 32'h5A5A);
        #1;
        checks++;
        if (GPIOOUT !== exp_out(16'h5A5A, PARITYSEL)) begin
            errors++;
            $display("FAIL out_in_mode: GPIOOUT=%h expected %h",
                     GPIOOUT, exp_out(16'h5A5A, PARITYSEL));
        end
        // Output mode freezes data-in and PARITYERR.
        GPIOIN    = 17'h0_0001;
        PARITYSEL = 1'b0;
        step();
        bus_write(8'h04, 32'h1);
        GPIOIN = 17'h1_0001;
        step();
        step();
        bus_write(8'h04, 32'h0);
        #1;
        checks++;
        if (PARITYERR !== exp_perr(17'h0_0001, 1'b0)) begin
            errors++;
            $display("FAIL perr_hold: PARITYERR=%b expected %b",
                     PARITYERR, exp_perr(17'h0_0001, 1'b0));
        end
    endtask

    task automatic test_regmap();
        bus_write(8'h04, 32'h1);
        read_check(8'h04, 32'h1, "read_dir");
        read_check(8'h08, 32'h0, "read_unmapped");
        bus_write(8'h08, 32'hFFFF);
        read_check(8'h00, 32'h5A5A, "write_unmapped");
    endtask

    task automatic test_back_to_back();
        HSEL   = 1'b1;
        HTRANS = 2'b10;
        HWRITE = 1'b1;
        HADDR  = 32'h0;
        step();
        HWDATA = 32'h1234;
        HWRITE = 1'b0;
        exp_q.push_back(32'h0000_1234);
        checks++;
        if (HREADYOUT !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready: HREADYOUT=%b expected 1", HREADYOUT);
        end
        step();
        bus_idle();
        #2;
        begin
            logic [31:0] want;
            want = exp_q.pop_front();
            checks++;
            if (HRDATA !== want) begin
                errors++;
                $display("FAIL b2b_read: HRDATA=%h expected %h",
                         HRDATA, want);
            end
        end
        step();
    endtask

    task automatic test_idle();
        HSEL   = 1'b0;
        HTRANS = 2'b10;
        HWRITE = 1'b1;
        HADDR  = 32'h0;
        step();
        bus_idle();
        HWDATA = 32'hFFFF;
        step();
        HSEL   = 1'b1;
        HTRANS = 2'b00;
        HWRITE = 1'b1;
        HADDR  = 32'h4;
        step();
        bus_idle();
        HWDATA = 32'h0;
        step();
        HSEL   = 1'b1;
        HTRANS = 2'b10;
        HREADY = 1'b0;
        HWRITE = 1'b1;
        HADDR  = 32'h0;
        step();
        bus_idle();
        HREADY = 1'b1;
        HWDATA = 32'hAAAA;
        step();
        checks++;
        if (GPIOOUT[15:0] !== 16'h1234 || GPIODIR !== 1'b1) begin
            errors++;
            $display("FAIL idle: GPIOOUT=%h dir=%b expected 1234/1",
                     GPIOOUT[15:0], GPIODIR);
        end
    endtask

    task automatic test_reset_mid();
        PARITYSEL = 1'b1;
        HSEL   = 1'b1;
        HTRANS = 2'b10;
        HWRITE = 1'b1;
        HADDR  = 32'h0;
        step();
        bus_idle();
        HWDATA = 32'hBEEF;
        #2;
        HRESETn = 1'b1;
        #1;
        checks++;
        if (GPIOOUT !== exp_out(16'h0, 1'b1) || GPIODIR !== 1'b0 ||
            PARITYERR !== 1'b0 || HRDATA !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid: out=%h dir=%b perr=%b rd=%h",
                     GPIOOUT, GPIODIR, PARITYERR, HRDATA);
        end
        step();
        HRESETn = 1'b0;
        step();
        step();
        checks++;
        if (GPIOOUT !== exp_out(16'h0, 1'b1)) begin
            errors++;
            $display("FAIL reset_drop: GPIOOUT=%h expected %h",
                     GPIOOUT, exp_out(16'h0, 1'b1));
        end
    endtask

    initial begin
        HRESETn   = 1'b1;
        bus_idle();
        HWDATA    = 32'h0;
        HREADY    = 1'b1;
        GPIOIN    = 17'h0;
        PARITYSEL = 1'b0;
        test_reset();
        test_output();
        test_input();
        test_regmap();
        test_back_to_back();
        test_idle();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard: %0d entries left expected 0",
                     exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/ahb_gpio_parity.md
Name: ahb_gpio_parity

Overview:
AHB-Lite slave GPIO port with a 16-bit data path plus one parity bit, on the system AHB bus beside the other AHB peripherals.
- Two bus-visible registers: data and direction.
- In output mode, drives GPIOOUT with the written data plus a generated parity bit.
- In input mode, samples GPIOIN and checks its parity bit. PARITYSEL selects even or odd parity.

Parameters:
- GPIO_WIDTH, 16, data bits per port; the parity bit sits at index GPIO_WIDTH.

Ports:
- HCLK  input  1  bus clock; all state on rising edge.
- HRESETn  input  1  asynchronous, active-high reset; asserted = 1. Name kept for codebase consistency.
- HADDR  input  32  AHB address; only HADDR[7:0] decoded.
- HTRANS  input  2  AHB transfer type; HTRANS[1]=1 means NONSEQ/SEQ.
- HWDATA  input  32  write data.
- HWRITE  input  1  1=write, 0=read.
- HSEL  input  1  slave select.
- HREADY  input  1  bus ready (previous transfer complete).
- GPIOIN  input  GPIO_WIDTH+1  [15:0] input data, [16] incoming parity bit.
- PARITYSEL  input  1  0=even parity, 1=odd parity.
- HREADYOUT  output  1  slave ready; constant 1 (zero wait states).
- HRDATA  output  32  read data.
- GPIOOUT  output  GPIO_WIDTH+1  [15:0] output data register, [16] generated parity.
- PARITYERR  output  1  registered parity-error flag for input data.
- GPIODIR  output  1  current direction: 1=output, 0=input.

Behaviour:
- Address phase is valid when HSEL & HREADY & HTRANS[1]. On HCLK rise, latch HWRITE and HADDR[7:0] with a valid flag; otherwise clear the valid flag.
- Data phase (next cycle): if the latched write is valid, HWDATA[15:0] goes to the decoded register.
  - 0x00: data-out register.
  - 0x04: direction; HWDATA[0] written to GPIODIR.
  - Other offsets: write ignored.
- Back-to-back transfers: each address phase overlaps the previous data phase. No stall; HREADYOUT=1 always.
- Input sampling: every cycle with GPIODIR=0, register GPIOIN[15:0] into data-in and compute the PARITYERR next value.
  - Even (PARITYSEL=0): expected parity = XOR of GPIOIN[15:0].
  - Odd (PARITYSEL=1): expected parity = inverted XOR.
  - PARITYERR next = GPIOIN[16] != expected.
- With GPIODIR=1, data-in and PARITYERR hold their values.
- GPIOOUT[15:0] = data-out register. GPIOOUT[16] = combinational parity of the data-out register under the current PARITYSEL; a PARITYSEL change takes effect immediately.
- HRDATA is combinational from the latched read address (zero-extended to 32 bits):
  - 0x00: data-in when GPIODIR=0, data-out register when GPIODIR=1.
  - 0x04: {31'b0, GPIODIR}.
  - Other offsets: 0.
- A write to the data register while GPIODIR=0 still updates the data-out register; GPIOOUT reflects it.
- Reset: all registers clear immediately on assertion, including mid-transfer; the in-flight transfer is dropped.
  - Cleared: data-out, data-in, GPIODIR, PARITYERR, latched address/write/valid.
  - GPIOOUT = {parity(0), 16'h0}: bit16=0 even, 1 odd. HRDATA=0.

Optional Feature:
- Macro GPIO_PARITY_EN.
- Defined: parity generation on GPIOOUT[16] and parity checking on PARITYERR, as above.
- Undefined:
  - GPIOOUT[16] tied 0 and PARITYERR tied 0.
  - GPIOIN[16] and PARITYSEL ignored.
  - Data path and register map unchanged.

Test Plan:
- Reset held 5 cycles -> GPIOOUT=0, GPIODIR=0, PARITYERR=0, HRDATA=0, HREADYOUT=1.
- Write 0x04=1, then write 0x00=0x00A5 with PARITYSEL=0 -> GPIODIR=1, GPIOOUT=0x000A5 (bit16=0, four ones); with PARITYSEL=1, GPIOOUT=0x100A5.
- GPIODIR=0, PARITYSEL=0, GPIOIN=0x1_0001, read 0x00 -> HRDATA=0x00000001, PARITYERR=0. Then GPIOIN=0x0_0001 -> PARITYERR=1 one cycle later.
- Read 0x04 after writing 1 -> HRDATA=0x00000001. Read 0x08 -> HRDATA=0.
- Back-to-back write 0x00=0x1234 then read 0x00 with GPIODIR=1 -> read returns 0x00001234, no wait states.
- Transfer with HSEL=0 or HTRANS=IDLE -> no register change. Reset asserted mid-transfer -> all outputs return to reset values immediately.
